// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } pipe_state_e;

  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam logic [4:0]  REG_X0   = 5'd0;

  // True when an ID source operand is actually read and names the given register.
  function automatic logic src_matches(input logic       use_src,
                                       input logic [4:0] src_addr,
                                       input logic [4:0] rd_addr);
    return use_src && (src_addr == rd_addr);
  endfunction

endpackage

// File: rtl/pipe_wait_fsm.sv
// Data-memory wait sequencer: RUN / MEM_WAIT / ERROR with a saturating
// timeout counter and a sticky error flag.
module pipe_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_access,
  input  logic        dmem_ack,
  output pipe_state_e state,
  output logic        ctrl_err
);

  pipe_state_e      state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             err_d, err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (mem_access && !dmem_ack) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_W'(MEM_TIMEOUT)) begin
          // Counter holds at the limit; it never wraps back to zero.
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERROR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign state    = state_q;
  assign ctrl_err = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional performance counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_mem_read,
  input  logic        mem_redirect,
  input  logic        mem_access,
  input  logic        dmem_ack,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_stall,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        ctrl_err,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  pipe_state_e state;
  logic        load_use;
  logic        mem_hold;

  pipe_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_access (mem_access),
    .dmem_ack   (dmem_ack),
    .state      (state),
    .ctrl_err   (ctrl_err)
  );

  assign load_use = ex_mem_read && (ex_rd_addr != REG_X0) &&
                    (src_matches(id_use_rs1, id_rs1_addr, ex_rd_addr) ||
                     src_matches(id_use_rs2, id_rs2_addr, ex_rd_addr));

  // Pipeline freezes on error, during a wait, or on the cycle a wait starts.
  assign mem_hold = (state == ERROR) ||
                    (!dmem_ack && ((state == MEM_WAIT) || mem_access));

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (rst) begin
      if (mem_hold) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end else if (mem_redirect) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  // Only a redirect ever raises ifid_flush, so it doubles as the redirect event.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, pc_stall};
    flush_cnt_d = flush_cnt_q + {31'd0, ifid_flush};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl against a behavioural pipeline-control model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_use_rs1, id_use_rs2, ex_mem_read;
  logic        mem_redirect, mem_access, dmem_ack;
  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic        exmem_stall, exmem_flush, memwb_flush, ctrl_err;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model: are we waiting on memory, for how many wait cycles, have we timed out.
  bit          m_wait;
  bit          m_err;
  int          m_waited;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (T),
    .CNT_W       (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd_addr     (ex_rd_addr),
    .ex_mem_read    (ex_mem_read),
    .mem_redirect   (mem_redirect),
    .mem_access     (mem_access),
    .dmem_ack       (dmem_ack),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .ifid_flush     (ifid_flush),
    .idex_stall     (idex_stall),
    .idex_flush     (idex_flush),
    .exmem_stall    (exmem_stall),
    .exmem_flush    (exmem_flush),
    .memwb_flush    (memwb_flush),
    .ctrl_err       (ctrl_err),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  // Bit order: pc, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_f, err
  function automatic logic [8:0] observed();
    return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
            exmem_stall, exmem_flush, memwb_flush, ctrl_err};
  endfunction

  function automatic bit hazard_in_id();
    logic [4:0] reads[$];
    if (!ex_mem_read || ex_rd_addr == 5'd0) return 0;
    if (id_use_rs1) reads.push_back(id_rs1_addr);
    if (id_use_rs2) reads.push_back(id_rs2_addr);
    foreach (reads[i]) if (reads[i] == ex_rd_addr) return 1;
    return 0;
  endfunction

  function automatic logic [8:0] expected();
    logic [8:0] freeze, redirect, bubble;
    freeze   = 9'b110101010;
    redirect = 9'b001010100;
    bubble   = 9'b110010000;
    if (!rst) return 9'd0;
    if (m_err) return freeze | 9'd1;
    if (!dmem_ack && (m_wait || mem_access)) return freeze;
    if (mem_redirect) return redirect;
    if (hazard_in_id()) return bubble;
    return 9'd0;
  endfunction

  task automatic idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    mem_redirect = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic model_clear();
    m_wait = 0; m_err = 0; m_waited = 0;
    m_stall_cnt = '0; m_flush_cnt = '0;
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge.
  task automatic step(input string name);
    logic [8:0] exp, act;
    #1;
    exp = expected();
    act = observed();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %b want %b", name, act, exp);
    end
    checks++;
    if ((act[7] & act[6]) | (act[5] & act[4]) | (act[3] & act[2])) begin
      errors++;
      $display("FAIL %s_exclusive: stall/flush pair both high, got %b want no pair", name, act);
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== m_stall_cnt || perf_flush_cnt !== m_flush_cnt) begin
      errors++;
      $display("FAIL %s_perf: got %0d/%0d want %0d/%0d", name,
               perf_stall_cnt, perf_flush_cnt, m_stall_cnt, m_flush_cnt);
    end
`else
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL %s_perf_tied: got %0d/%0d want 0/0", name, perf_stall_cnt, perf_flush_cnt);
    end
`endif
    if (rst) begin
      m_stall_cnt += {31'd0, exp[8]};
      m_flush_cnt += {31'd0, exp[6]};
      if (!m_err) begin
        if (m_wait) begin
          if (dmem_ack) m_wait = 0;
          else if (m_waited == int'(T)) begin m_err = 1; m_wait = 0; end
          else m_waited++;
        end else if (mem_access && !dmem_ack) begin
          m_wait = 1; m_waited = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b0;
    #1;
    checks++;
    if (observed() !== 9'd0) begin
      errors++;
      $display("FAIL %s: outputs in reset got %b want 000000000", name, observed());
    end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    mem_access = 1'b1; mem_redirect = 1'b1;
    @(negedge clk);
    do_reset("reset_outputs");
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_stall_cnt, perf_flush_cnt);
    end
    idle();
    step("reset_idle");
  endtask

  task automatic test_load_use();
    idle();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_use_rs1 = 1'b1;
    #1;
    checks++;
    if ({pc_stall, ifid_stall, idex_flush} !== 3'b111) begin
      errors++;
      $display("FAIL load_use_rs1: got %b want 111", {pc_stall, ifid_stall, idex_flush});
    end
    #1;
    @(negedge clk);
    ex_mem_read = 1'b0;
    step("load_use_clears");
    ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0;
    step("load_use_x0");
    ex_rd_addr = 5'd9; id_rs1_addr = 5'd3; id_rs2_addr = 5'd9; id_use_rs2 = 1'b1;
    step("load_use_rs2");
    id_use_rs2 = 1'b0;
    step("load_use_rs2_unused");
    idle();
  endtask

  task automatic test_redirect_priority();
    idle();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd7; id_rs2_addr = 5'd7; id_use_rs2 = 1'b1;
    mem_redirect = 1'b1;
    step("redirect_over_load_use");
    idle();
  endtask

  task automatic test_mem_wait();
    idle();
    mem_access = 1'b1;
    for (int unsigned i = 0; i < 3; i++) step("mem_wait_hold");
    dmem_ack = 1'b1;
    mem_redirect = 1'b1;
    step("mem_wait_ack_redirect");
    idle();
    mem_redirect = 1'b1;
    step("mem_wait_back_in_run");
    idle();
  endtask

  task automatic test_timeout();
    idle();
    mem_access = 1'b1;
    for (int unsigned i = 0; i < 1 + T + 3; i++) step("timeout_seq");
    checks++;
    if (ctrl_err !== 1'b1 || pc_stall !== 1'b1 || memwb_flush !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: err/pc/memwb got %b%b%b want 111", ctrl_err, pc_stall, memwb_flush);
    end
    dmem_ack = 1'b1; mem_access = 1'b0;
    step("timeout_ack_ignored");
    do_reset("timeout_reset");
    idle();
    step("timeout_after_reset");
  endtask

  task automatic test_async_reset();
    idle();
    mem_access = 1'b1;
    step("async_enter");
    step("async_wait");
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (observed() !== 9'd0) begin
      errors++;
      $display("FAIL async_reset_drop: got %b want 000000000", observed());
    end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int unsigned i = 0; i < 1 + T + 1; i++) step("async_fresh_wait");
    do_reset("async_cleanup");
    idle();
  endtask

  task automatic test_perf();
    do_reset("perf_reset");
    idle();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd4; id_rs1_addr = 5'd4; id_use_rs1 = 1'b1;
    step("perf_lu1");
    idle();
    step("perf_gap");
    ex_mem_read = 1'b1; ex_rd_addr = 5'd6; id_rs2_addr = 5'd6; id_use_rs2 = 1'b1;
    step("perf_lu2");
    idle();
    mem_access = 1'b1;
    for (int unsigned i = 0; i < 3; i++) step("perf_wait");
    dmem_ack = 1'b1;
    step("perf_ack");
    idle();
    mem_redirect = 1'b1;
    step("perf_redirect");
    idle();
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== 32'd5 || perf_flush_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_totals: got %0d/%0d want 5/1", perf_stall_cnt, perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 400; i++) begin
      if (m_err || $urandom_range(0, 99) == 0) do_reset("random_reset");
      id_rs1_addr  = 5'($urandom_range(0, 3));
      id_rs2_addr  = 5'($urandom_range(0, 3));
      ex_rd_addr   = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      ex_mem_read  = 1'($urandom_range(0, 1));
      mem_redirect = ($urandom_range(0, 3) == 0);
      mem_access   = ($urandom_range(0, 3) == 0);
      dmem_ack     = ($urandom_range(0, 9) < 6);
      step("random");
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_clear();
    test_reset();
    test_load_use();
    test_redirect_priority();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_perf();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
